// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: state encoding,
// default operand width and a constant-friendly ceiling-log2 helper.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned DEFAULT_WIDTH = 6;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned v;
        result = 0;
        v      = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/serial_sub_cell.sv
// Combinational full-adder bit cell; the subtrahend bit arrives pre-inverted.
module serial_sub_cell (
    input  logic a_bit,
    input  logic nb_bit,
    input  logic cin,
    output logic s,
    output logic cout
);

    always_comb begin
        s    = a_bit ^ nb_bit ^ cin;
        cout = (a_bit & nb_bit) | (a_bit & cin) | (nb_bit & cin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a + ~b + 1, LSB first,
// one bit per clock, with start/busy/done handshake and result flags.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned CntW = clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             overflow_q, overflow_d;
    logic             zero_q, zero_d;

    logic sum_bit;
    logic carry_out;

    serial_sub_cell u_cell (
        .a_bit  (a_sh_q[0]),
        .nb_bit (b_sh_q[0]),
        .cin    (carry_q),
        .s      (sum_bit),
        .cout   (carry_out)
    );

    always_comb begin
        state_d    = state_q;
        a_sh_d     = a_sh_q;
        b_sh_d     = b_sh_q;
        res_d      = res_q;
        cnt_d      = cnt_q;
        carry_d    = carry_q;
        diff_d     = diff_q;
        borrow_d   = borrow_q;
        overflow_d = overflow_q;
        zero_d     = zero_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = ~b;
                    res_d   = '0;
                    carry_d = 1'b1;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                res_d   = {sum_bit, res_q[WIDTH-1:1]};
                carry_d = carry_out;
                cnt_d   = cnt_q + CntW'(1);
                if (cnt_q == LastBit) begin
                    // carry_q is the carry into the MSB on this final bit.
                    diff_d     = res_d;
                    borrow_d   = ~carry_out;
                    overflow_d = carry_q ^ carry_out;
                    zero_d     = (res_d == '0);
                    state_d    = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            a_sh_q     <= '0;
            b_sh_q     <= '0;
            res_q      <= '0;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            diff_q     <= '0;
            borrow_q   <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_sh_q     <= a_sh_d;
            b_sh_q     <= b_sh_d;
            res_q      <= res_d;
            cnt_q      <= cnt_d;
            carry_q    <= carry_d;
            diff_q     <= diff_d;
            borrow_q   <= borrow_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
        end
    end

    always_comb begin
        busy     = (state_q == RUN);
        done     = (state_q == DONE);
        diff     = diff_q;
        borrow   = borrow_q;
        overflow = overflow_q;
        zero     = zero_q;
    end

endmodule
